rps_round_ctrl: RTL
===================

Name: rps_round_ctrl

Overview:
Round controller for the rock-paper-scissors game. It sits directly downstream of the two per-player hold timers and consumes each timer's hit_target level as "gesture held long enough". It locks each player's gesture, judges the round, keeps score, holds the result for display, and waits for both players to release before the next round.

Parameters:
SCORE_W, 4, width of each score counter
WIN_SCORE, 3, score that ends the match; must be at most 2^SCORE_W-1
SHOW_CYCLES, 50, number of cycles the result is held in SHOW; must be at least 1
SHOW_W, 8, width of the SHOW counter; must satisfy SHOW_CYCLES < 2^SHOW_W

Ports:
clk  in  1  system clock; all logic is on the rising edge
reset  in  1  synchronous, active-low reset; reset==0 at a rising edge resets the block
start  in  1  begins a match from IDLE
p1_hit  in  1  player-1 timer hit_target (level)
p2_hit  in  1  player-2 timer hit_target (level)
p1_move  in  2  player-1 gesture: 00 none, 01 rock, 10 paper, 11 scissors
p2_move  in  2  player-2 gesture, same encoding
p1_locked  out  1  player-1 gesture captured this round
p2_locked  out  1  player-2 gesture captured this round
result  out  2  00 none, 01 P1 wins, 10 P2 wins, 11 tie
result_valid  out  1  one-cycle pulse when result updates
p1_score  out  SCORE_W  player-1 wins this match
p2_score  out  SCORE_W  player-2 wins this match
match_over  out  1  high once either score reaches WIN_SCORE
state_o  out  3  current state, for debug and display

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, all lock flags 0, captured moves 00, result 00, result_valid 0, both scores 0, match_over 0, show counter 0.
- Reset has priority over every other event in every state, including mid-round.
- State encoding: IDLE=0, COLLECT=1, JUDGE=2, SHOW=3, WAIT_REL=4.
- IDLE:
  - start==1 moves to COLLECT at the next edge and clears locks and result to 00.
  - If match_over==1 at that edge, scores and match_over are also cleared.
  - start is ignored in all other states.
- COLLECT, per player independently:
  - If not locked, pX_hit==1 and pX_move!=00: capture pX_move and set pX_locked at that edge, so the lock is visible the next cycle.
  - pX_move==00 with pX_hit==1 is ignored; no lock.
  - Once locked, the captured move is frozen. Later changes on pX_move or pX_hit have no effect.
  - Both players may lock on the same edge.
  - When both locked registers are 1, the next edge goes to JUDGE.
- JUDGE (exactly 1 cycle). The edge leaving JUDGE does all of the following:
  - Writes result: rock beats scissors, scissors beats paper, paper beats rock; equal moves give 11.
  - Sets result_valid=1 for exactly one cycle.
  - Increments the winner's score, saturating at 2^SCORE_W-1; a tie changes no score.
  - Sets match_over if the updated score equals WIN_SCORE.
  - Enters SHOW with the show counter at 0.
- SHOW:
  - result and scores hold.
  - The counter increments each cycle.
  - When the counter equals SHOW_CYCLES-1, the next edge enters WAIT_REL.
  - Total SHOW dwell is SHOW_CYCLES cycles.
- WAIT_REL:
  - Holds until p1_hit==0 and p2_hit==0 in the same cycle. This prevents a still-held gesture from relocking.
  - On that edge: if match_over==1, go to IDLE and retain result and scores for display.
  - Otherwise go to COLLECT, clearing locks, captured moves and result to 00.
- Latency: second lock edge N → JUDGE during cycle N+1 → result, result_valid and score updated at edge N+2.
- result_valid is 0 everywhere except the first cycle of SHOW.

Test Plan:
- Reset low for 2 cycles mid-SHOW with p1_score=2 → next cycle state_o=0, scores 0, result 00, locks 0, result_valid 0.
- start; p1 hit with move 01 (rock) on cycle 3; p2 hit with move 11 (scissors) on cycle 6 → p1_locked at cycle 4, p2_locked at cycle 7, JUDGE at cycle 8, result=01 and result_valid=1 for one cycle at cycle 9, p1_score=1; SHOW dwell of 50 cycles; WAIT_REL until both hits are 0.
- Both hit the same edge with 10/10 → both locks set together; result=11; scores unchanged.
- p1_hit=1 with p1_move=00 for 5 cycles, then move 10 → lock only on the first cycle with move 10; a p1_move change after lock is ignored and the captured value stays 10.
- Keep p2_hit high through SHOW and into WAIT_REL for 7 extra cycles → state stays WAIT_REL, no relock; COLLECT only after release.
- Three P2 wins (paper vs rock) → p2_score=3, match_over=1, return to IDLE after release; start then clears scores and match_over and enters COLLECT.

Source files
------------

// File: rtl/rps_round_ctrl.sv
// Rock-paper-scissors round controller: locks both players' gestures, judges the
// round, keeps score, holds the result for display and waits for release.
module rps_round_ctrl #(
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 3,
  parameter int SHOW_CYCLES = 50,
  parameter int SHOW_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               p1_hit,
  input  logic               p2_hit,
  input  logic [1:0]         p1_move,
  input  logic [1:0]         p2_move,
  output logic               p1_locked,
  output logic               p2_locked,
  output logic [1:0]         result,
  output logic               result_valid,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic               match_over,
  output logic [2:0]         state_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_COLLECT  = 3'd1,
    S_JUDGE    = 3'd2,
    S_SHOW     = 3'd3,
    S_WAIT_REL = 3'd4
  } state_t;

  localparam logic [1:0] MV_NONE  = 2'b00;
  localparam logic [1:0] MV_ROCK  = 2'b01;
  localparam logic [1:0] MV_PAPER = 2'b10;
  localparam logic [1:0] MV_SCIS  = 2'b11;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_P1   = 2'b01;
  localparam logic [1:0] RES_P2   = 2'b10;
  localparam logic [1:0] RES_TIE  = 2'b11;

  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0] SCORE_WIN = SCORE_W'(WIN_SCORE);
  localparam logic [SHOW_W-1:0]  SHOW_LAST = SHOW_W'(SHOW_CYCLES - 1);

  state_t             state_r;
  logic               p1_locked_r, p2_locked_r;
  logic [1:0]         p1_move_r, p2_move_r;
  logic [1:0]         result_r;
  logic               result_valid_r;
  logic [SCORE_W-1:0] p1_score_r, p2_score_r;
  logic               match_over_r;
  logic [SHOW_W-1:0]  show_cnt_r;

  logic [1:0]         round_res_s;
  logic [SCORE_W-1:0] p1_score_nxt_s, p2_score_nxt_s;
  logic               match_over_nxt_s;

  // Outcome of a round between two non-empty gestures, seen from player 1.
  function automatic logic [1:0] judge(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] res;
    if (a == b) begin
      res = RES_TIE;
    end else if ((a == MV_ROCK  && b == MV_SCIS)  ||
                 (a == MV_SCIS  && b == MV_PAPER) ||
                 (a == MV_PAPER && b == MV_ROCK)) begin
      res = RES_P1;
    end else begin
      res = RES_P2;
    end
    return res;
  endfunction

  // Round outcome and saturating score update applied on the edge leaving JUDGE.
  always_comb begin
    round_res_s    = judge(p1_move_r, p2_move_r);
    p1_score_nxt_s = p1_score_r;
    p2_score_nxt_s = p2_score_r;
    if (round_res_s == RES_P1 && p1_score_r != SCORE_MAX) begin
      p1_score_nxt_s = p1_score_r + SCORE_W'(1'b1);
    end else if (round_res_s == RES_P2 && p2_score_r != SCORE_MAX) begin
      p2_score_nxt_s = p2_score_r + SCORE_W'(1'b1);
    end else begin
      p1_score_nxt_s = p1_score_r;
    end
    match_over_nxt_s = match_over_r
                     | ((round_res_s == RES_P1) && (p1_score_nxt_s == SCORE_WIN))
                     | ((round_res_s == RES_P2) && (p2_score_nxt_s == SCORE_WIN));
  end

  // Round FSM with all observable state held in registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r        <= S_IDLE;
      p1_locked_r    <= 1'b0;
      p2_locked_r    <= 1'b0;
      p1_move_r      <= MV_NONE;
      p2_move_r      <= MV_NONE;
      result_r       <= RES_NONE;
      result_valid_r <= 1'b0;
      p1_score_r     <= '0;
      p2_score_r     <= '0;
      match_over_r   <= 1'b0;
      show_cnt_r     <= '0;
    end else begin
      result_valid_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            state_r     <= S_COLLECT;
            p1_locked_r <= 1'b0;
            p2_locked_r <= 1'b0;
            p1_move_r   <= MV_NONE;
            p2_move_r   <= MV_NONE;
            result_r    <= RES_NONE;
            if (match_over_r) begin
              p1_score_r   <= '0;
              p2_score_r   <= '0;
              match_over_r <= 1'b0;
            end
          end
        end
        S_COLLECT: begin
          if (p1_locked_r && p2_locked_r) begin
            state_r <= S_JUDGE;
          end else begin
            if (!p1_locked_r && p1_hit && p1_move != MV_NONE) begin
              p1_locked_r <= 1'b1;
              p1_move_r   <= p1_move;
            end
            if (!p2_locked_r && p2_hit && p2_move != MV_NONE) begin
              p2_locked_r <= 1'b1;
              p2_move_r   <= p2_move;
            end
          end
        end
        S_JUDGE: begin
          state_r        <= S_SHOW;
          result_r       <= round_res_s;
          result_valid_r <= 1'b1;
          p1_score_r     <= p1_score_nxt_s;
          p2_score_r     <= p2_score_nxt_s;
          match_over_r   <= match_over_nxt_s;
          show_cnt_r     <= '0;
        end
        S_SHOW: begin
          if (show_cnt_r == SHOW_LAST) begin
            state_r    <= S_WAIT_REL;
            show_cnt_r <= '0;
          end else begin
            show_cnt_r <= show_cnt_r + SHOW_W'(1'b1);
          end
        end
        S_WAIT_REL: begin
          // Both gestures must drop together so a held hand cannot relock.
          if (!p1_hit && !p2_hit) begin
            if (match_over_r) begin
              state_r <= S_IDLE;
            end else begin
              state_r     <= S_COLLECT;
              p1_locked_r <= 1'b0;
              p2_locked_r <= 1'b0;
              p1_move_r   <= MV_NONE;
              p2_move_r   <= MV_NONE;
              result_r    <= RES_NONE;
            end
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign p1_locked    = p1_locked_r;
  assign p2_locked    = p2_locked_r;
  assign result       = result_r;
  assign result_valid = result_valid_r;
  assign p1_score     = p1_score_r;
  assign p2_score     = p2_score_r;
  assign match_over   = match_over_r;
  assign state_o      = state_r;

endmodule
